// File: rtl/dac_update_scheduler.sv
// Captures register-bank update strobes into shadow copies and serialises one
// 24-bit SPI mode-0 write per pending channel, granted round-robin.
module dac_update_scheduler #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2,
  parameter logic [3:0]  DAC_CMD = 4'h3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  upd,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [15:0] val2,
  input  logic [15:0] val3,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_mosi,
  output logic        busy,
  output logic [3:0]  pending,
  output logic        frame_done,
  output logic [1:0]  done_ch
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD = 8'(CS_GAP - 1);

  state_t            state, state_d;
  logic [3:0]        upd_q;
  logic [3:0]        req;
  logic [3:0][15:0]  val_in;
  logic [3:0][15:0]  shadow, shadow_d;
  logic [3:0]        pending_d;
  logic [1:0]        last, last_d;
  logic [23:0]       sr, sr_d;
  logic [7:0]        div_cnt, div_d;
  logic [4:0]        bit_cnt, bit_d;
  logic [7:0]        gap_cnt, gap_d;
  logic              cs_n_d, sclk_d, busy_d, frame_done_d;
  logic [1:0]        done_ch_d;
  logic              grant_found;
  logic [1:0]        grant_ch;
  logic [1:0]        cand;

  assign val_in = {val3, val2, val1, val0};
  assign req    = upd & ~upd_q;

  // mosi is the shift-register MSB; the register is cleared when the frame ends
  assign dac_mosi = sr[23];

  always_comb begin
    grant_ch    = last;
    grant_found = 1'b0;
    cand        = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!grant_found && pending[cand]) begin
        grant_ch    = cand;
        grant_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state;
    shadow_d     = shadow;
    pending_d    = pending;
    last_d       = last;
    sr_d         = sr;
    div_d        = div_cnt;
    bit_d        = bit_cnt;
    gap_d        = gap_cnt;
    cs_n_d       = dac_cs_n;
    sclk_d       = dac_sclk;
    busy_d       = busy;
    frame_done_d = 1'b0;
    done_ch_d    = done_ch;

    unique case (state)
      IDLE: begin
        if (en && grant_found) begin
          state_d             = SHIFT;
          last_d              = grant_ch;
          sr_d                = {DAC_CMD, 2'b00, grant_ch, shadow[grant_ch]};
          pending_d[grant_ch] = 1'b0;
          cs_n_d              = 1'b0;
          sclk_d              = 1'b0;
          busy_d              = 1'b1;
          div_d               = DIV_LOAD;
          bit_d               = 5'd23;
        end
      end
      SHIFT: begin
        if (div_cnt != '0) begin
          div_d = div_cnt - 8'd1;
        end else begin
          div_d = DIV_LOAD;
          if (!dac_sclk) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt == '0) begin
              state_d = HOLD;
            end else begin
              bit_d = bit_cnt - 5'd1;
              sr_d  = {sr[22:0], 1'b0};
            end
          end
        end
      end
      HOLD: begin
        if (div_cnt != '0) begin
          div_d = div_cnt - 8'd1;
        end else begin
          state_d      = GAP;
          cs_n_d       = 1'b1;
          sr_d         = '0;
          frame_done_d = 1'b1;
          done_ch_d    = last;
          gap_d        = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt != '0) begin
          gap_d = gap_cnt - 8'd1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A request landing on the grant edge re-arms the channel after the clear
    for (int unsigned i = 0; i < 4; i++) begin
      if (req[i]) begin
        pending_d[i] = 1'b1;
        shadow_d[i]  = val_in[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      upd_q      <= '0;
      shadow     <= '0;
      pending    <= '0;
      last       <= 2'd3;
      sr         <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      done_ch    <= '0;
    end else begin
      state      <= state_d;
      upd_q      <= upd;
      shadow     <= shadow_d;
      pending    <= pending_d;
      last       <= last_d;
      sr         <= sr_d;
      div_cnt    <= div_d;
      bit_cnt    <= bit_d;
      gap_cnt    <= gap_d;
      dac_cs_n   <= cs_n_d;
      dac_sclk   <= sclk_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      done_ch    <= done_ch_d;
    end
  end

endmodule
